// File: rtl/miner_pkg.sv
// rtl/miner_pkg.sv - shared constants and dispatch state type for the miner nonce dispatcher
package miner_pkg;
  localparam int CHUNK_W      = 512;
  localparam int HASH_W       = 256;
  localparam int TAIL_W       = 96;
  localparam int MSG_LEN_BITS = 640;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    WAIT,
    CHECK,
    DONE
  } dispatch_state_t;
endpackage

// File: rtl/miner_core_timer.sv
// rtl/miner_core_timer.sv - enable-gated cycle counter with a rollover flag
module miner_core_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         enable_timer,
  input  logic [W-1:0] rollover_val,
  output logic         rollover_flag
);
  logic [W-1:0] r_count;

  // Dropping enable clears the count, so each enabled window starts from zero.
  assign rollover_flag = enable_timer && (r_count == (rollover_val - 1'b1));

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_count <= '0;
    end else if (!enable_timer || rollover_flag) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + 1'b1;
    end
  end
endmodule

// File: rtl/miner_nonce_dispatch.sv
// rtl/miner_nonce_dispatch.sv - walks a nonce range through one miner core and reports the first hit
module miner_nonce_dispatch
  import miner_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              job_start,
  input  logic              abort,
  input  logic [TAIL_W-1:0] header_tail,
  input  logic [31:0]       nonce_start,
  input  logic [31:0]       nonce_end,
  input  logic [HASH_W-1:0] target,
  output logic [0:CHUNK_W-1] chunk,
  output logic              hash_enable,
  input  logic              finished,
  input  logic [HASH_W-1:0] hash,
  output logic              busy,
  output logic              done,
  output logic              found,
  output logic [31:0]       found_nonce,
  output logic              error
);
  localparam logic [7:0] TIMEOUT_VAL = TIMEOUT_CYCLES[7:0];

  dispatch_state_t   r_state;
  dispatch_state_t   w_next;
  logic [TAIL_W-1:0] r_tail;
  logic [31:0]       r_nonce;
  logic [31:0]       r_end;
  logic [HASH_W-1:0] r_target;
  logic [HASH_W-1:0] r_hash;
  logic              r_chunk_en;
  logic              r_done;
  logic              r_found;
  logic [31:0]       r_found_nonce;
  logic              r_error;
  logic              w_accept;
  logic              w_hit;
  logic              w_last;
  logic              w_timeout;
  logic              w_abort;

  miner_core_timer #(.W(8)) u_watchdog (
    .clk          (clk),
    .n_rst        (n_rst),
    .enable_timer (r_state == WAIT),
    .rollover_val (TIMEOUT_VAL),
    .rollover_flag(w_timeout)
  );

  assign busy     = (r_state == LOAD) || (r_state == WAIT) || (r_state == CHECK);
  assign w_accept = ((r_state == IDLE) || (r_state == DONE)) && job_start;
  assign w_abort  = abort && busy;
  assign w_hit    = r_hash < r_target;
  assign w_last   = r_nonce == r_end;

  assign hash_enable = (r_state == LOAD);
  assign done        = r_done;
  assign found       = r_found;
  assign found_nonce = r_found_nonce;
  assign error       = r_error;

  // Held at zero until the first job so reset leaves the core input quiet.
  assign chunk = r_chunk_en ? {r_tail, r_nonce, 1'b1, 319'b0, 64'(MSG_LEN_BITS)} : '0;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (job_start) w_next = LOAD;
      LOAD:    w_next = WAIT;
      WAIT: begin
        if (finished)       w_next = CHECK;
        else if (w_timeout) w_next = DONE;
      end
      CHECK:   w_next = (w_hit || w_last) ? DONE : LOAD;
      DONE:    if (job_start) w_next = LOAD;
      default: w_next = IDLE;
    endcase
    if (w_abort) w_next = IDLE;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_tail        <= '0;
      r_nonce       <= '0;
      r_end         <= '0;
      r_target      <= '0;
      r_hash        <= '0;
      r_chunk_en    <= 1'b0;
      r_done        <= 1'b0;
      r_found       <= 1'b0;
      r_found_nonce <= '0;
      r_error       <= 1'b0;
    end else begin
      if (w_accept) begin
        r_tail     <= header_tail;
        r_nonce    <= nonce_start;
        r_end      <= nonce_end;
        r_target   <= target;
        r_chunk_en <= 1'b1;
        r_done     <= 1'b0;
        r_found    <= 1'b0;
        r_error    <= 1'b0;
      end
      if ((r_state == WAIT) && finished) begin
        r_hash <= hash;
      end
      if ((r_state == WAIT) && !finished && w_timeout && !w_abort) begin
        r_error <= 1'b1;
        r_done  <= 1'b1;
      end
      if ((r_state == CHECK) && !w_abort) begin
        if (w_hit) begin
          r_found       <= 1'b1;
          r_found_nonce <= r_nonce;
          r_done        <= 1'b1;
        end else if (w_last) begin
          r_done <= 1'b1;
        end else begin
          r_nonce <= r_nonce + 32'd1;
        end
      end
    end
  end
endmodule
